// File: rtl/reel_stop_ctrl.sv
// rtl/reel_stop_ctrl.sv - stop-button front end: key sync, debounce, press toggle, tick gating
module reel_stop_ctrl #(
    parameter int DB_BITS        = 16,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic i_sclr,
    input  logic i_key,
    input  logic i_tick,
    output logic o_en,
    output logic o_run,
    output logic o_press
);

    typedef enum logic {SPIN = 1'b0, STOP = 1'b1} state_t;

    logic               key_k;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               stable_q, stable_d;
    logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;
    logic               press_q, press_d;
    state_t             state_q, state_d;

    assign key_k = KEY_ACTIVE_LOW ? ~i_key : i_key;

    always_comb begin
        sync1_d  = key_k;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        press_d  = 1'b0;
        state_d  = state_q;

        // Any cycle agreeing with the accepted level restarts the window.
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != '1) begin
            db_cnt_d = db_cnt_q + DB_BITS'(1);
        end else begin
            stable_d = sync2_q;
            db_cnt_d = '0;
            press_d  = sync2_q;
        end

        if (press_q) begin
            state_d = (state_q == SPIN) ? STOP : SPIN;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
            state_q  <= SPIN;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
            state_q  <= state_d;
        end
    end

    // A tick coinciding with the press still passes; gating starts once the state flips.
    assign o_run   = (state_q == SPIN);
    assign o_en    = i_tick & (state_q == SPIN);
    assign o_press = press_q;

endmodule

// File: tb/tb_reel_stop_ctrl.sv
// tb/tb_reel_stop_ctrl.sv - directed scoreboard bench for reel_stop_ctrl with a 4-cycle debounce window
module tb_reel_stop_ctrl;

    logic clk;
    logic i_sclr;
    logic i_key;
    logic i_tick;
    logic o_en;
    logic o_run;
    logic o_press;

    int    tests_run;
    int    tests_failed;
    int    cyc;
    string phase;
    logic [2:0] sb_q[$];

    reel_stop_ctrl #(.DB_BITS(2), .KEY_ACTIVE_LOW(1'b1)) dut (
        .clk     (clk),
        .i_sclr  (i_sclr),
        .i_key   (i_key),
        .i_tick  (i_tick),
        .o_en    (o_en),
        .o_run   (o_run),
        .o_press (o_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs just after an edge, compare mid-cycle, return just after the next edge.
    task automatic step(input bit pressed, input bit tick, input bit sclr, input bit ep, input bit er);
        logic [2:0] exp_v;
        i_key  = ~pressed;
        i_tick = tick;
        i_sclr = sclr;
        sb_q.push_back({tick & er, er, ep});
        @(negedge clk);
        exp_v = sb_q.pop_front();
        tests_run++;
        assert (o_en === exp_v[2]) else begin
            tests_failed++;
            $error("FAIL %s.o_en cycle %0d: got %b expected %b", phase, cyc, o_en, exp_v[2]);
        end
        tests_run++;
        assert (o_run === exp_v[1]) else begin
            tests_failed++;
            $error("FAIL %s.o_run cycle %0d: got %b expected %b", phase, cyc, o_run, exp_v[1]);
        end
        tests_run++;
        assert (o_press === exp_v[0]) else begin
            tests_failed++;
            $error("FAIL %s.o_press cycle %0d: got %b expected %b", phase, cyc, o_press, exp_v[0]);
        end
        @(posedge clk);
        #1;
    endtask

    // Key held steady for n cycles; no pulse expected, ticks every 4th cycle.
    task automatic hold(input string name, input bit pressed, input int n, input bit er);
        phase = name;
        for (int c = 0; c < n; c++) begin
            cyc = c;
            step(pressed, (c % 4) == 0, 1'b0, 1'b0, er);
        end
    endtask

    // Press from a clean released state: pulse in cycle 6, state flips from cycle 7.
    task automatic press_seq(input string name, input bit run0, input int tick_mode);
        bit tick;
        phase = name;
        for (int c = 0; c < 14; c++) begin
            cyc = c;
            case (tick_mode)
                1:       tick = (c == 6) || (c == 10);
                2:       tick = (c == 6) || (c == 7) || (c == 10);
                default: tick = (c % 4) == 0;
            endcase
            step(1'b1, tick, 1'b0, c == 6, (c <= 6) ? run0 : ~run0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        phase        = "reset";
        i_sclr = 1'b1;
        i_key  = 1'b1;
        i_tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state and tick pass-through with no key.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hold("passthru", 1'b0, 16, 1'b1);

        // Bounce: 3 cycles pressed, 3 released, never long enough to be accepted.
        phase = "bounce";
        for (int c = 0; c < 30; c++) begin
            cyc = c;
            step(((c / 3) % 2) == 0, (c % 4) == 0, 1'b0, 1'b0, 1'b1);
        end
        hold("bounce_rel", 1'b0, 10, 1'b1);

        // Clean press stops the reel; holding gives no further pulse.
        press_seq("press_stop", 1'b1, 0);
        hold("hold_stop", 1'b1, 50, 1'b0);

        // Release then press again restarts spinning.
        hold("release1", 1'b0, 10, 1'b0);
        press_seq("press_spin", 1'b0, 0);
        hold("hold_spin", 1'b1, 50, 1'b1);

        // Tick coincides with the press while spinning: passes, later ticks blocked.
        hold("release2", 1'b0, 10, 1'b1);
        press_seq("coinc_spin", 1'b1, 1);
        hold("release3", 1'b0, 10, 1'b0);

        // Reset during debounce from STOP: state returns to SPIN, press re-detected after a full window.
        phase = "sclr_mid";
        for (int c = 0; c < 16; c++) begin
            cyc = c;
            step(1'b1, (c % 4) == 0, c == 4, c == 11, (c <= 4) ? 1'b0 : (c <= 11));
        end
        hold("release4", 1'b0, 10, 1'b0);

        // Tick coincides with the press while stopped: blocked, next-cycle tick passes.
        press_seq("coinc_stop", 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
